// File: rtl/risc_v_cpu_core.sv
// risc_v_cpu_core: single-cycle 32-bit RISC-V-style core with private byte-addressed memories.
// Optional feature macro: RISC_V_CPU_JAL_LINK_EN (JAL writes pc+4 to rd when defined).

module risc_v_instruction_memory #(
    parameter int BYTES = 1024
) (
    input  logic        clock,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [7:0]  wdata,
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [7:0] memory [0:BYTES-1];

    function automatic logic [AW-1:0] wrap(input logic [31:0] a);
        return AW'(a % 32'(BYTES));
    endfunction

    always_ff @(posedge clock) begin
        if (we) memory[wrap(waddr)] <= wdata;
    end

    assign data = {memory[wrap(addr + 32'd3)], memory[wrap(addr + 32'd2)],
                   memory[wrap(addr + 32'd1)], memory[wrap(addr)]};
endmodule

module risc_v_data_memory #(
    parameter int BYTES = 1024
) (
    input  logic        clock,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [7:0] memory [0:BYTES-1];

    function automatic logic [AW-1:0] wrap(input logic [31:0] a);
        return AW'(a % 32'(BYTES));
    endfunction

    always_ff @(posedge clock) begin
        if (we) begin
            for (int k = 0; k < 4; k++) memory[wrap(addr + 32'(k))] <= wdata[8*k +: 8];
        end
    end

    assign rdata = {memory[wrap(addr + 32'd3)], memory[wrap(addr + 32'd2)],
                    memory[wrap(addr + 32'd1)], memory[wrap(addr)]};
endmodule

module risc_v_register_bank (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [0:31];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && rd != 5'd0) begin
            registers[rd] <= wdata;
        end
    end

    assign rdata1 = (rs1 == 5'd0) ? 32'd0 : registers[rs1];
    assign rdata2 = (rs2 == 5'd0) ? 32'd0 : registers[rs2];
endmodule

module risc_v_program_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic [31:0] pc_addr
);
    always_ff @(posedge clock) begin
        if (reset) pc_addr <= '0;
        else       pc_addr <= next_pc;
    end
endmodule

module risc_v_cpu_core #(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] out
);
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [31:0] pc, inst, rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_j, imm_u;
    logic [31:0] mem_addr, load_val, wb_val, next_pc;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        rf_we, dmem_we;
    logic        unused_bits;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub, input logic arith,
                                        input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [4:0] sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (f3)
            3'd0:    alu = sub ? a - b : a + b;
            3'd1:    alu = a << sh;
            3'd2:    alu = {31'd0, sa < sb};
            3'd3:    alu = {31'd0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = arith ? $unsigned(sa >>> sh) : a >> sh;
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    branch_taken = (a == b);
            3'd1:    branch_taken = (a != b);
            3'd4:    branch_taken = (sa < sb);
            3'd5:    branch_taken = (sa >= sb);
            3'd6:    branch_taken = (a < b);
            3'd7:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    risc_v_program_counter program_counter (
        .clock   (clock),
        .reset   (reset),
        .next_pc (next_pc),
        .pc_addr (pc)
    );

    // The write port exists only so the array has a driver; contents come from preload.
    risc_v_instruction_memory #(.BYTES(IMEM_BYTES)) uut_instruction (
        .clock (clock),
        .we    (1'b0),
        .waddr (32'd0),
        .wdata (8'd0),
        .addr  (pc),
        .data  (inst)
    );

    risc_v_register_bank registers_bank (
        .clock  (clock),
        .reset  (reset),
        .we     (rf_we),
        .rd     (rd),
        .wdata  (wb_val),
        .rs1    (rs1),
        .rs2    (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    risc_v_data_memory #(.BYTES(DMEM_BYTES)) data_memory (
        .clock (clock),
        .we    (dmem_we && !reset),
        .addr  (mem_addr),
        .wdata (rs2_val),
        .rdata (load_val)
    );

    assign opcode      = inst[6:2];
    assign rd          = inst[11:7];
    assign funct3      = inst[14:12];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = &{1'b0, inst[1:0]};

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_j = {{12{inst[31]}}, inst[31:12]};
    assign imm_u = {inst[31:12], 12'd0};

    assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    always_comb begin
        rf_we   = 1'b0;
        dmem_we = 1'b0;
        wb_val  = 32'd0;
        next_pc = pc + 32'd4;
        case (opcode)
            OPC_OP_IMM: begin
                rf_we  = 1'b1;
                wb_val = alu(funct3, 1'b0, inst[30], rs1_val, imm_i);
            end
            OPC_OP: begin
                rf_we  = 1'b1;
                wb_val = alu(funct3, inst[30], inst[30], rs1_val, rs2_val);
            end
            OPC_LOAD: begin
                rf_we  = 1'b1;
                wb_val = load_val;
            end
            OPC_STORE:  dmem_we = 1'b1;
            OPC_BRANCH: if (branch_taken(funct3, rs1_val, rs2_val)) next_pc = pc + imm_s;
            OPC_JAL: begin
                next_pc = pc + imm_j;
`ifdef RISC_V_CPU_JAL_LINK_EN
                rf_we  = 1'b1;
                wb_val = pc + 32'd4;
`else
                rf_we  = 1'b0;
`endif
            end
            OPC_LUI: begin
                rf_we  = 1'b1;
                wb_val = imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)                      out <= '0;
        else if (rf_we && rd != 5'd0)   out <= wb_val;
    end
endmodule

// File: tb/tb_risc_v_cpu_core.sv
// Self-checking bench for risc_v_cpu_core: directed programs plus random instruction streams
// compared cycle by cycle against an instruction-level reference model.

module tb_risc_v_cpu_core;
    localparam int MB = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] core_out;
    int          n_tests = 0;
    int          n_fail = 0;

    risc_v_cpu_core #(.IMEM_BYTES(MB), .DMEM_BYTES(MB)) dut (
        .clock (clock),
        .reset (reset),
        .out   (core_out)
    );

    always #5 clock = ~clock;

    // Reference machine state
    logic [7:0]  m_imem [0:MB-1];
    logic [7:0]  m_dmem [0:MB-1];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc, m_out, prev_pc;
    logic [4:0]  m_last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] a, input logic is_imem);
        logic [31:0] w, p;
        w = '0;
        for (int k = 3; k >= 0; k--) begin
            p = a + 32'(k);
            w = {w[23:0], is_imem ? m_imem[p[9:0]] : m_dmem[p[9:0]]};
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic minus,
                                            input logic arith, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0:    return minus ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return arith ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i[4:0]] = '0;
        m_pc = '0;
        m_out = '0;
        m_last_rd = '0;
        prev_pc = 32'hFFFF_FFFF;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, r, addr, nxt, imm_i, imm_sb, imm_j;
        logic        wr, take;
        logic [4:0]  rd;
        ins    = m_word(m_pc, 1'b1);
        rd     = ins[11:7];
        a      = m_regs[ins[19:15]];
        b      = m_regs[ins[24:20]];
        imm_i  = 32'($signed(ins[31:20]));
        imm_sb = 32'($signed({ins[31:25], ins[11:7]}));
        imm_j  = 32'($signed(ins[31:12]));
        r      = '0;
        wr     = 1'b0;
        take   = 1'b0;
        nxt    = m_pc + 32'd4;
        case (ins[6:2])
            5'b00100: begin wr = 1'b1; r = ref_alu(ins[14:12], 1'b0, ins[30], a, imm_i); end
            5'b01100: begin wr = 1'b1; r = ref_alu(ins[14:12], ins[30], ins[30], a, b); end
            5'b00000: begin wr = 1'b1; r = m_word(a + imm_i, 1'b0); end
            5'b01000: begin
                for (int k = 0; k < 4; k++) begin
                    addr = a + imm_sb + 32'(k);
                    m_dmem[addr[9:0]] = b[8*k +: 8];
                end
            end
            5'b11000: begin
                case (ins[14:12])
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) < $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a < b);
                    3'd7: take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take) nxt = m_pc + imm_sb;
            end
            5'b11011: begin
                nxt = m_pc + imm_j;
`ifdef RISC_V_CPU_JAL_LINK_EN
                wr = 1'b1;
                r  = m_pc + 32'd4;
`endif
            end
            5'b01101: begin wr = 1'b1; r = {ins[31:12], 12'h000}; end
            default: ;
        endcase
        if (wr && rd != 5'd0) begin
            m_regs[rd] = r;
            m_out = r;
        end
        m_last_rd = rd;
        prev_pc = m_pc;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] dut_reg(input logic [4:0] i);
        return dut.registers_bank.registers[i];
    endfunction

    function automatic logic [31:0] dut_pc();
        return dut.program_counter.pc_addr;
    endfunction

    function automatic logic [31:0] dut_dword(input logic [31:0] a);
        logic [31:0] w, p;
        w = '0;
        for (int k = 3; k >= 0; k--) begin
            p = a + 32'(k);
            w = {w[23:0], dut.data_memory.memory[p[9:0]]};
        end
        return w;
    endfunction

    task automatic put_word(input logic [31:0] byte_addr, input logic [31:0] w);
        logic [31:0] p;
        for (int k = 0; k < 4; k++) begin
            p = byte_addr + 32'(k);
            m_imem[p[9:0]] = w[8*k +: 8];
            dut.uut_instruction.memory[p[9:0]] = w[8*k +: 8];
        end
    endtask

    task automatic load_nops();
        for (int w = 0; w < MB / 4; w++) put_word(32'(w * 4), 32'h0000_0013);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 5'b00100, 2'b11};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 5'b01100, 2'b11};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0, 1: w[6:2] = 5'b00100;
            2, 3: w[6:2] = 5'b01100;
            4:    w[6:2] = 5'b00000;
            5:    w[6:2] = 5'b01000;
            6:    begin w[6:2] = 5'b11000; w[8:7] = 2'b00; end
            7:    begin w[6:2] = 5'b11011; w[13:12] = 2'b00; end
            8:    w[6:2] = 5'b01101;
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick_check();
        @(posedge clock);
        if (reset) model_reset();
        else       model_step();
        #1;
        check("pc", dut_pc(), m_pc);
        check("out", core_out, m_out);
        check("rd_value", dut_reg(m_last_rd), m_regs[m_last_rd]);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) check(tag, dut_reg(i[4:0]), m_regs[i[4:0]]);
    endtask

    initial begin
        int          fib_idx, n;
        logic [31:0] fx, fy, ft;
        logic [7:0]  bt;

        model_reset();
        for (int i = 0; i < MB; i++) begin
            m_dmem[i[9:0]] = 8'h00;
            dut.data_memory.memory[i[9:0]] = 8'h00;
        end

        // Fibonacci program
        load_nops();
        put_word(0,  32'h0010_0310);
        put_word(4,  32'h0000_0390);
        put_word(8,  32'h0003_0410);
        put_word(12, 32'h0073_0330);
        put_word(16, 32'h0004_0390);
        put_word(20, 32'hFFFF_42EC);
        tick_check();
        tick_check();
        check("reset_pc", dut_pc(), 32'd0);
        check("reset_out", core_out, 32'd0);
        for (int i = 0; i < 32; i++) check("reset_reg", dut_reg(i[4:0]), 32'd0);
        reset = 1'b0;
        fib_idx = 0;
        fx = 32'd1;
        fy = 32'd1;
        ft = 32'd0;
        for (int c = 1; c <= 52; c++) begin
            tick_check();
            if (c == 1) check("fib_x6_init", dut_reg(5'd6), 32'd1);
            if (c == 2) check("fib_x7_init", dut_reg(5'd7), 32'd0);
            if (c == 3) check("fib_x8_init", dut_reg(5'd8), 32'd1);
            if (prev_pc == 32'd20) begin
                check("fib_jal_pc", dut_pc(), 32'd8);
                check("fib_jal_x7", dut_reg(5'd7), ft);
            end
            if (prev_pc == 32'd16 && fib_idx < 12) begin
                check("fib_x7", dut_reg(5'd7), fx);
                ft = fx;
                fx = fy;
                fy = ft + fy;
                fib_idx++;
            end
        end
        check("fib_loops", 32'(fib_idx), 32'd12);

        // Store / branch loop with a reset pulse in the middle
        reset = 1'b1;
        load_nops();
        put_word(0,  enc_i(12'd10, 5'd0, 3'd0, 5'd1));
        put_word(4,  enc_i(12'd10, 5'd0, 3'd0, 5'd2));
        put_word(8,  enc_i(12'd0,  5'd0, 3'd0, 5'd3));
        put_word(12, {7'd0, 5'd2, 5'd0, 3'b010, 5'd0, 5'b01000, 2'b11});
        put_word(16, enc_i(12'hFFF, 5'd2, 3'd0, 5'd2));
        put_word(20, enc_i(12'd1,   5'd3, 3'd0, 5'd3));
        put_word(24, 32'hFE20_1C60);
        tick_check();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) tick_check();
        reset = 1'b1;
        tick_check();
        reset = 1'b0;
        check("midrst_pc", dut_pc(), 32'd0);
        check("midrst_out", core_out, 32'd0);
        for (int i = 0; i < 32; i++) check("midrst_reg", dut_reg(i[4:0]), 32'd0);
        check("midrst_dmem", dut_dword(32'd0), 32'h0000_000A);
        check("midrst_imem", {dut.uut_instruction.memory[27], dut.uut_instruction.memory[26],
                              dut.uut_instruction.memory[25], dut.uut_instruction.memory[24]},
              32'hFE20_1C60);
        n = 0;
        while (m_pc != 32'd28 && n < 200) begin
            tick_check();
            n++;
        end
        check("sb_pc", dut_pc(), 32'd28);
        check("sb_x1", dut_reg(5'd1), 32'd10);
        check("sb_x2", dut_reg(5'd2), 32'd0);
        check("sb_x3", dut_reg(5'd3), 32'd10);
        check("sb_dmem", dut_dword(32'd0), 32'h0000_000A);

        // Sign / shift corner cases and write to x0
        reset = 1'b1;
        load_nops();
        put_word(0,  {20'h80000, 5'd5, 5'b01101, 2'b11});
        put_word(4,  enc_i(12'd1, 5'd0, 3'd0, 5'd6));
        put_word(8,  enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd7));
        put_word(12, enc_r(7'h00, 5'd6, 5'd5, 3'b011, 5'd9));
        put_word(16, enc_r(7'h20, 5'd6, 5'd5, 3'b101, 5'd8));
        put_word(20, enc_i(12'd5, 5'd0, 3'd0, 5'd0));
        tick_check();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick_check();
        check("lui_x5", dut_reg(5'd5), 32'h8000_0000);
        check("sub", dut_reg(5'd7), 32'h7FFF_FFFF);
        check("sltu", dut_reg(5'd9), 32'h0000_0000);
        check("sra", dut_reg(5'd8), 32'hC000_0000);
        check("x0_zero", dut_reg(5'd0), 32'd0);
        check("x0_out_hold", core_out, 32'hC000_0000);

        // Random instruction streams with occasional resets
        reset = 1'b1;
        for (int w = 0; w < MB / 4; w++) put_word(32'(w * 4), rand_inst());
        for (int i = 0; i < MB; i++) begin
            bt = 8'($urandom());
            m_dmem[i[9:0]] = bt;
            dut.data_memory.memory[i[9:0]] = bt;
        end
        tick_check();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            tick_check();
        end
        reset = 1'b0;
        check_regs("rand_reg");
        for (int w = 0; w < MB / 4; w++)
            check("rand_dmem", dut_dword(32'(w * 4)), m_word(32'(w * 4), 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
